step_dir_generator: RTL and testbench

STEP_DIR_GENERATOR -- requirements
Module: step_dir_generator

---
 rtl/step_dir_generator_if.sv | 26 ++
 rtl/step_dir_generator.sv | 128 ++++++++++++
 tb/tb_step_dir_generator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/step_dir_generator_if.sv
// rtl/step_dir_generator_if.sv - move request and step/dir output bundle
interface step_dir_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             dir_in;
  logic [CNT_W-1:0] steps;
  logic [CNT_W-1:0] period;
  logic [7:0]       pulse_width;
  logic             abort;
  logic             step_out;
  logic             dir_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, dir_in, steps, period, pulse_width, abort,
    input  step_out, dir_out, busy, done, remaining
  );

  modport slave (
    input  start, dir_in, steps, period, pulse_width, abort,
    output step_out, dir_out, busy, done, remaining
  );
endinterface

// File: rtl/step_dir_generator.sv
// rtl/step_dir_generator.sv - step/direction pulse generator FSM
module step_dir_generator #(
  parameter int DIR_SETUP = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  step_dir_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(DIR_SETUP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_m1;
  logic [CNT_W-1:0] low_m1;
  logic             abort_pend;

  logic [CNT_W-1:0] pw_in;
  logic [CNT_W-1:0] low_in;
  logic [CNT_W-1:0] high_m1_in;
  logic [CNT_W-1:0] low_m1_in;
  logic             abort_now;

  // Phase lengths are resolved once at start so period/pulse_width are free to change mid-move.
  always_comb begin
    pw_in      = (bus.pulse_width == 8'd0) ? ONE : CNT_W'(bus.pulse_width);
    low_in     = (bus.period > pw_in) ? (bus.period - pw_in) : ONE;
    high_m1_in = pw_in - ONE;
    low_m1_in  = low_in - ONE;
    abort_now  = abort_pend | bus.abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      high_m1       <= '0;
      low_m1        <= '0;
      abort_pend    <= 1'b0;
      bus.step_out  <= 1'b0;
      bus.dir_out   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.dir_out   <= bus.dir_in;
            bus.remaining <= bus.steps;
            high_m1       <= high_m1_in;
            low_m1        <= low_m1_in;
            cnt           <= SETUP_M1;
            bus.busy      <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (bus.abort) abort_pend <= 1'b1;
          if (cnt == '0) begin
            if (bus.remaining == '0 || abort_now) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.step_out  <= 1'b1;
              bus.remaining <= bus.remaining - ONE;
              cnt           <= high_m1;
              state         <= HIGH;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        HIGH: begin
          if (bus.abort) abort_pend <= 1'b1;
          if (cnt == '0) begin
            bus.step_out <= 1'b0;
            cnt          <= low_m1;
            state        <= LOW;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        LOW: begin
          if (bus.abort) abort_pend <= 1'b1;
          if (cnt == '0) begin
            // A pending abort only takes effect here, after a full HIGH+LOW.
            if (bus.remaining != '0 && !abort_now) begin
              bus.step_out  <= 1'b1;
              bus.remaining <= bus.remaining - ONE;
              cnt           <= high_m1;
              state         <= HIGH;
            end else begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= FINISH;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        FINISH: begin
          bus.done   <= 1'b0;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.step_out <= 1'b0;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b0;
          abort_pend   <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_step_dir_generator.sv
// tb/tb_step_dir_generator.sv - scoreboard bench for step_dir_generator
module tb_step_dir_generator;
  localparam int CNT_W = 16;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int               kind;
    int               cyc;
    logic [CNT_W-1:0] rem;
    logic             dir;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic prev_step = 1'b0;
  ev_t  exp_q[$];

  step_dir_if #(.CNT_W(CNT_W)) sif ();

  step_dir_generator #(.DIR_SETUP(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input int rem, input logic dir);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.rem  = CNT_W'(rem);
    e.dir  = dir;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d rem=%0d dir=%0b (no event required)",
               kind, cyc, sif.remaining, sif.dir_out);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.rem != sif.remaining || e.dir != sif.dir_out) begin
        n_miss++;
        $display("FAIL event got kind=%0d cyc=%0d rem=%0d dir=%0b, required kind=%0d cyc=%0d rem=%0d dir=%0b",
                 kind, cyc, sif.remaining, sif.dir_out, e.kind, e.cyc, e.rem, e.dir);
      end
    end
  endtask

  // Monitor: turns step_out edges and done pulses into events for the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sif.step_out && !prev_step) check_ev(K_RISE);
      if (!sif.step_out && prev_step) check_ev(K_FALL);
      if (sif.done) check_ev(K_DONE);
    end
    prev_step = rst ? 1'b0 : sif.step_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic start_move(input logic dir, input int st, input int per, input int pw, output int s);
    @(negedge clk);
    sif.start       = 1'b1;
    sif.dir_in      = dir;
    sif.steps       = CNT_W'(st);
    sif.period      = CNT_W'(per);
    sif.pulse_width = 8'(pw);
    @(posedge clk);
    #1;
    s = cyc;
    sif.start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s_drain got=%0d pending events required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int busy_cnt;
    sif.start = 1'b0; sif.dir_in = 1'b0; sif.steps = '0;
    sif.period = '0; sif.pulse_width = '0; sif.abort = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_step_out", 32'(sif.step_out), 0);
    chk("reset_dir_out", 32'(sif.dir_out), 0);
    chk("reset_busy", 32'(sif.busy), 0);
    chk("reset_done", 32'(sif.done), 0);
    chk("reset_remaining", 32'(sif.remaining), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 3 pulses, 3 high / 7 low, forward
    start_move(1'b1, 3, 10, 3, s);
    push(K_RISE, s+4, 2, 1'b1);  push(K_FALL, s+7, 2, 1'b1);
    push(K_RISE, s+14, 1, 1'b1); push(K_FALL, s+17, 1, 1'b1);
    push(K_RISE, s+24, 0, 1'b1); push(K_FALL, s+27, 0, 1'b1);
    push(K_DONE, s+34, 0, 1'b1);
    wait_drain("three_pulses", 60);

    // steps=0: no pulse, done after setup, busy for 4 cycles
    start_move(1'b1, 0, 10, 3, s);
    push(K_DONE, s+4, 0, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sif.busy) busy_cnt++;
    end
    chk("zero_steps_busy_cycles", 32'(busy_cnt), 4);
    wait_drain("zero_steps", 20);

    // abort in IDLE must not be remembered; then pw=0, period=1 toggles every cycle
    @(negedge clk); sif.abort = 1'b1;
    repeat (2) @(negedge clk); sif.abort = 1'b0;
    start_move(1'b0, 4, 1, 0, s);
    push(K_RISE, s+4, 3, 1'b0);  push(K_FALL, s+5, 3, 1'b0);
    push(K_RISE, s+6, 2, 1'b0);  push(K_FALL, s+7, 2, 1'b0);
    push(K_RISE, s+8, 1, 1'b0);  push(K_FALL, s+9, 1, 1'b0);
    push(K_RISE, s+10, 0, 1'b0); push(K_FALL, s+11, 0, 1'b0);
    push(K_DONE, s+12, 0, 1'b0);
    wait_drain("fast_toggle", 40);

    // abort during SETUP: zero pulses, remaining untouched
    start_move(1'b1, 3, 10, 3, s);
    sif.abort = 1'b1;
    @(posedge clk); #1 sif.abort = 1'b0;
    push(K_DONE, s+4, 3, 1'b1);
    wait_drain("setup_abort", 20);

    // abort during pulse 5 HIGH: pulse 5 completes, remaining stays 95
    start_move(1'b1, 100, 20, 3, s);
    for (int k = 0; k < 5; k++) begin
      push(K_RISE, s+4+20*k, 99-k, 1'b1);
      push(K_FALL, s+7+20*k, 99-k, 1'b1);
    end
    push(K_DONE, s+104, 95, 1'b1);
    while (cyc < s+84) @(negedge clk);
    #2 sif.abort = 1'b1;
    @(posedge clk); #1 sif.abort = 1'b0;
    wait_drain("mid_abort", 60);
    chk("mid_abort_remaining", 32'(sif.remaining), 95);

    // start held high with new operands: second move only after returning to IDLE
    @(negedge clk);
    sif.start = 1'b1; sif.dir_in = 1'b0; sif.steps = 16'd2;
    sif.period = 16'd4; sif.pulse_width = 8'd2;
    @(posedge clk); #1 s = cyc;
    sif.dir_in = 1'b1; sif.steps = 16'd1; sif.period = 16'd3; sif.pulse_width = 8'd1;
    push(K_RISE, s+4, 1, 1'b0);  push(K_FALL, s+6, 1, 1'b0);
    push(K_RISE, s+8, 0, 1'b0);  push(K_FALL, s+10, 0, 1'b0);
    push(K_DONE, s+12, 0, 1'b0);
    push(K_RISE, s+18, 0, 1'b1); push(K_FALL, s+19, 0, 1'b1);
    push(K_DONE, s+21, 0, 1'b1);
    while (cyc < s+14) @(negedge clk);
    sif.start = 1'b0;
    wait_drain("held_start", 30);

    // asynchronous reset mid-HIGH, then a single-step move right after release
    start_move(1'b1, 5, 10, 5, s);
    push(K_RISE, s+4, 4, 1'b1);
    while (cyc < s+5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_step_out", 32'(sif.step_out), 0);
    chk("async_rst_busy", 32'(sif.busy), 0);
    chk("async_rst_dir_out", 32'(sif.dir_out), 0);
    chk("async_rst_remaining", 32'(sif.remaining), 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    sif.start = 1'b1; sif.dir_in = 1'b1; sif.steps = 16'd1;
    sif.period = 16'd6; sif.pulse_width = 8'd2;
    @(posedge clk); #1 s = cyc;
    sif.start = 1'b0;
    push(K_RISE, s+4, 0, 1'b1); push(K_FALL, s+6, 0, 1'b1);
    push(K_DONE, s+10, 0, 1'b1);
    wait_drain("post_reset", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
